// File: rtl/nn_pkg.sv
// nn_pkg -- definitions shared by the network controllers.
//   state_t        : result collector FSM encoding
//   SAMPLES_DEF    : default number of samples per run
//   N_CLASS_DEF    : default number of output-layer scores per sample
//   ADDR_W / CLS_W : sample-index and class-index widths
//   CLS_CNT_W      : width of the per-sample score counter
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LABEL   = 3'd2,
    S_CMP     = 3'd3,
    S_NEXT    = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam int SAMPLES_DEF = 750;
  localparam int N_CLASS_DEF = 3;
  localparam int ADDR_W      = 10;
  localparam int CLS_W       = 2;
  localparam int CLS_CNT_W   = 8;

endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker -- running signed maximum and its index.
//   clk, rst : clock, asynchronous active-low reset
//   first    : the enabled score starts a new sample (load unconditionally)
//   en       : a score is presented this cycle
//   score    : signed score
//   idx      : class index of the score
//   max      : largest score seen so far in this sample
//   argmax   : index of that score; ties keep the lower index
module argmax_tracker #(
  parameter int DW = 8,
  parameter int IW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 first,
  input  logic                 en,
  input  logic signed [DW-1:0] score,
  input  logic        [IW-1:0] idx,
  output logic signed [DW-1:0] max,
  output logic        [IW-1:0] argmax
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max    <= '0;
      argmax <= '0;
    end else if (en) begin
      if (first) begin
        max    <= score;
        argmax <= '0;
      end else if (score > max) begin
        // Strict compare so an equal later score never steals the index.
        max    <= score;
        argmax <= idx;
      end
    end
  end

endmodule

// File: rtl/result_collector.sv
// result_collector -- gathers output-layer scores per sample, takes the
// argmax, compares it with the stored label and writes the prediction.
//   clk, rst          : clock, asynchronous active-low reset
//   start             : pulse that clears counters and begins a run (IDLE/FIN)
//   sc_valid/sc_ready : score handshake, sc_data signed score, sc_last ends sample
//   lbl_rd/lbl_addr   : label memory read; lbl_data arrives the next cycle
//   res_we/res_addr/res_data : prediction write
//   correct           : running count of correct predictions
//   busy / done       : run in progress / run complete (held until start)
//   dbg_state         : present FSM state, dbg_max : running max score
//
// Handshake: a score transfers on a rising edge where sc_valid and sc_ready
// are both high; sc_ready is high only in COLLECT, and the source must hold
// sc_valid/sc_data/sc_last stable until the transfer happens.
module result_collector
  import nn_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int DW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sc_valid,
  output logic                 sc_ready,
  input  logic signed [DW-1:0] sc_data,
  input  logic                 sc_last,
  output logic                 lbl_rd,
  output logic [ADDR_W-1:0]    lbl_addr,
  input  logic [CLS_W-1:0]     lbl_data,
  output logic                 res_we,
  output logic [ADDR_W-1:0]    res_addr,
  output logic [CLS_W-1:0]     res_data,
  output logic [ADDR_W-1:0]    correct,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state,
  output logic signed [DW-1:0] dbg_max
);

  localparam logic [ADDR_W-1:0]    SAMPLES_C = ADDR_W'(SAMPLES);
  localparam logic [CLS_CNT_W-1:0] N_CLASS_C = CLS_CNT_W'(N_CLASS);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_sample_cnt;
  logic [ADDR_W-1:0]     r_correct;
  logic [CLS_CNT_W-1:0]  r_cls_idx;

  logic                  w_hs;
  logic                  w_clear;
  logic                  w_in_range;
  logic                  w_trk_en;
  logic                  w_trk_first;
  logic signed [DW-1:0]  w_trk_score;
  logic signed [DW-1:0]  w_max;
  logic [CLS_W-1:0]      w_argmax;
  logic [ADDR_W-1:0]     w_cnt_nxt;

  assign w_hs       = (r_state == S_COLLECT) && sc_valid;
  assign w_clear    = start && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_in_range = (r_cls_idx < N_CLASS_C);
  assign w_cnt_nxt  = r_sample_cnt + ADDR_W'(1);

  // A run start reuses the tracker's load path with a zero score, which
  // clears max/argmax without a dedicated clear input.
  assign w_trk_en    = w_clear || (w_hs && w_in_range);
  assign w_trk_first = w_clear || (r_cls_idx == '0);
  assign w_trk_score = w_clear ? '0 : sc_data;

  argmax_tracker #(
    .DW (DW),
    .IW (CLS_W)
  ) u_tracker (
    .clk    (clk),
    .rst    (rst),
    .first  (w_trk_first),
    .en     (w_trk_en),
    .score  (w_trk_score),
    .idx    (r_cls_idx[CLS_W-1:0]),
    .max    (w_max),
    .argmax (w_argmax)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= '0;
      r_correct    <= '0;
      r_cls_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (start) begin
            r_state      <= S_COLLECT;
            r_sample_cnt <= '0;
            r_correct    <= '0;
            r_cls_idx    <= '0;
          end
        end
        S_COLLECT: begin
          if (w_hs) begin
            if (sc_last) begin
              r_cls_idx <= '0;
              r_state   <= S_LABEL;
            end else if (r_cls_idx != '1) begin
              // Saturate so a runaway sample can never wrap back into range.
              r_cls_idx <= r_cls_idx + CLS_CNT_W'(1);
            end
          end
        end
        S_LABEL: r_state <= S_CMP;
        S_CMP: begin
          // lbl_data answers the read issued in LABEL.
          if (lbl_data == w_argmax) r_correct <= r_correct + ADDR_W'(1);
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_sample_cnt <= w_cnt_nxt;
          r_state      <= (w_cnt_nxt == SAMPLES_C) ? S_FIN : S_COLLECT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode from the state register only.
  assign sc_ready  = (r_state == S_COLLECT);
  assign lbl_rd    = (r_state == S_LABEL);
  assign res_we    = (r_state == S_CMP);
  assign busy      = (r_state == S_COLLECT) || (r_state == S_LABEL) ||
                     (r_state == S_CMP)     || (r_state == S_NEXT);
  assign done      = (r_state == S_FIN);
  assign lbl_addr  = r_sample_cnt;
  assign res_addr  = r_sample_cnt;
  assign res_data  = w_argmax;
  assign correct   = r_correct;
  assign dbg_state = r_state;
  assign dbg_max   = w_max;

endmodule
